// File: rtl/fetch_unit_if.sv
// Decode-side handshake of the fetch stage: the head {pc, instr} pair offered
// over valid/ready.
interface fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
);
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the pc, samples combinational imem data into a
// small prefetch FIFO and drains it to decode; a redirect reloads pc and flushes.
module fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 8,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]         imem_instr,
    input  logic                       fetch_en,
    input  logic                       redirect_valid,
    input  logic [ADDR_W-1:0]          redirect_pc,
    fetch_unit_if.master               dec,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0]  pc_reg,    pc_next;
    logic [PTR_W-1:0]   head_reg,  head_next;
    logic [PTR_W-1:0]   tail_reg,  tail_next;
    logic [CNT_W-1:0]   count_reg, count_next;

    logic               empty;
    logic               full;
    logic               pop;
    logic               push;
    logic [DEPTH-1:0]   wr_en;
    logic [ENTRY_W-1:0] entry_rd [DEPTH];
    logic [ENTRY_W-1:0] head_entry;

    // Handshake decisions; redirect outranks everything and blocks the push.
    always_comb begin
        empty = (count_reg == '0);
        full  = (count_reg == CNT_W'(DEPTH));
        pop   = ~empty & dec.out_ready;
        push  = fetch_en & ~redirect_valid & (~full | pop);
    end

    always_comb begin
        pc_next    = pc_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (redirect_valid) begin
            pc_next    = redirect_pc;
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (push) begin
                pc_next   = pc_reg + ADDR_W'(1);
                tail_next = tail_reg + PTR_W'(1);
            end
            if (pop) begin
                head_next = head_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg    <= ADDR_W'(RESET_PC);
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            pc_reg    <= pc_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Entry storage needs no reset: outputs are gated to zero whenever empty.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
            logic [ENTRY_W-1:0] entry_reg;

            assign wr_en[gi] = push & (tail_reg == PTR_W'(gi));

            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    entry_reg <= {pc_reg, imem_instr};
                end
            end

            assign entry_rd[gi] = entry_reg;
        end
    endgenerate

    assign head_entry    = entry_rd[head_reg];
    assign imem_addr     = pc_reg;
    assign fifo_count    = count_reg;
    assign dec.out_valid = ~empty;
    assign dec.out_pc    = empty ? '0 : head_entry[ENTRY_W-1:INSTR_W];
    assign dec.out_instr = empty ? '0 : head_entry[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue model of the prefetch buffer checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_fetch_unit;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 8;
    localparam int DEPTH   = 4;

    typedef struct {
        int pc;
        int instr;
    } ent_t;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic [ADDR_W-1:0]          imem_addr;
    logic [INSTR_W-1:0]         imem_instr;
    logic                       fetch_en;
    logic                       redirect_valid;
    logic [ADDR_W-1:0]          redirect_pc;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    logic [INSTR_W-1:0]         mem [256];

    int   checks   = 0;
    int   failures = 0;
    int   pc_m     = 0;
    ent_t q[$];

    fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dec_if ();

    fetch_unit #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_addr(imem_addr),
        .imem_instr(imem_instr),
        .fetch_en(fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .dec(dec_if.master),
        .fifo_count(fifo_count)
    );

    assign imem_instr = mem[imem_addr];

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        pc_m = 0;
        q.delete();
    endtask

    // Reference behaviour: plain queue semantics of the prefetch buffer.
    task automatic model_step();
        bit   do_pop;
        bit   do_push;
        ent_t e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        do_pop = (q.size() != 0) && dec_if.out_ready;
        if (do_pop) begin
            $display("pop   pc=%02h instr=%02h%s", q[0].pc, q[0].instr,
                     redirect_valid ? " (squashed)" : "");
        end
        if (redirect_valid) begin
            pc_m = int'(redirect_pc);
            q.delete();
        end else begin
            do_push = fetch_en && ((q.size() < DEPTH) || do_pop);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.pc    = pc_m;
                e.instr = int'(mem[pc_m]);
                q.push_back(e);
                pc_m = (pc_m + 1) % 256;
            end
        end
    endtask

    task automatic compare_all();
        chk("imem_addr", int'(imem_addr), pc_m);
        chk("fifo_count", int'(fifo_count), q.size());
        chk("out_valid", int'(dec_if.out_valid), (q.size() != 0) ? 1 : 0);
        chk("out_pc", int'(dec_if.out_pc), (q.size() != 0) ? q[0].pc : 0);
        chk("out_instr", int'(dec_if.out_instr), (q.size() != 0) ? q[0].instr : 0);
    endtask

    // Inputs change on the falling edge; the model steps on the rising edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic redirect_to(input int target);
        redirect_valid = 1'b1;
        redirect_pc    = ADDR_W'(target);
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = INSTR_W'(i + 1);
        rst_n           = 1'b0;
        fetch_en        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        dec_if.out_ready = 1'b1;
        model_reset();

        tick();
        tick();
        chk("reset_valid", int'(dec_if.out_valid), 0);
        chk("reset_count", int'(fifo_count), 0);
        chk("reset_addr", int'(imem_addr), 0);
        chk("reset_instr", int'(dec_if.out_instr), 0);
        chk("reset_pc", int'(dec_if.out_pc), 0);

        // Streaming from reset: one instruction per cycle.
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stream_pc", int'(dec_if.out_pc), k);
            chk("stream_instr", int'(dec_if.out_instr), k + 1);
        end

        // Stall decode: buffer fills to DEPTH and pc stops.
        dec_if.out_ready = 1'b0;
        redirect_to(0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("stall_count", int'(fifo_count), (k < 4) ? k : 4);
        end
        chk("stall_addr", int'(imem_addr), 4);
        dec_if.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("drain_order_pc", int'(dec_if.out_pc), k);
            tick();
        end

        // Redirect in steady flow.
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        tick();
        redirect_valid = 1'b0;
        chk("redir_count", int'(fifo_count), 0);
        chk("redir_valid", int'(dec_if.out_valid), 0);
        tick();
        chk("redir_pc", int'(dec_if.out_pc), 'h40);
        chk("redir_instr", int'(dec_if.out_instr), 'h41);

        // pc wrap at the top of the address space.
        redirect_to('hFE);
        tick(); chk("wrap_pc0", int'(dec_if.out_pc), 'hFE);
        tick(); chk("wrap_pc1", int'(dec_if.out_pc), 'hFF);
        chk("wrap_instr1", int'(dec_if.out_instr), 0);
        tick(); chk("wrap_pc2", int'(dec_if.out_pc), 'h00);
        tick(); chk("wrap_pc3", int'(dec_if.out_pc), 'h01);

        // Full buffer with push and pop each cycle, then drain with fetch off.
        dec_if.out_ready = 1'b0;
        redirect_to('h10);
        repeat (4) tick();
        chk("full_count", int'(fifo_count), 4);
        dec_if.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("full_flow_count", int'(fifo_count), 4);
        end
        chk("full_flow_head", int'(dec_if.out_pc), 'h13);
        fetch_en = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            tick();
            chk("drain_count", int'(fifo_count), k);
            chk("drain_addr", int'(imem_addr), 'h17);
        end

        // Redirect with fetch disabled still loads pc; back-to-back redirects.
        redirect_to('h80);
        chk("nofetch_redir_addr", int'(imem_addr), 'h80);
        tick();
        chk("nofetch_hold_addr", int'(imem_addr), 'h80);
        fetch_en = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h20;
        tick();
        redirect_pc    = 8'h30;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("b2b_redir_pc", int'(dec_if.out_pc), 'h30);

        // Asynchronous reset mid-stream with three entries buffered.
        dec_if.out_ready = 1'b0;
        redirect_to(0);
        repeat (3) tick();
        chk("pre_rst_count", int'(fifo_count), 3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", int'(dec_if.out_valid), 0);
        chk("async_rst_count", int'(fifo_count), 0);
        chk("async_rst_addr", int'(imem_addr), 0);
        tick();
        rst_n = 1'b1;
        dec_if.out_ready = 1'b1;

        // Mixed pattern of stalls, fetch gaps and a redirect.
        for (int i = 0; i < 60; i++) begin
            dec_if.out_ready = (i % 3) != 0;
            fetch_en         = (i % 5) != 2;
            redirect_valid   = (i == 37);
            redirect_pc      = 8'hC7;
            tick();
        end
        redirect_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
